// File: rtl/bitsim_pkg.sv
// Shared types and constants for the bitmask scheduler: operand width,
// position index width, scheduler states and a position-to-mask helper.
package bitsim_pkg;

    localparam int PKG_W  = 8;
    localparam int PKG_IW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One-hot mask of the bit that an MSB-first position refers to
    // (position 0 is bit PKG_W-1, position PKG_W-1 is bit 0).
    function automatic logic [PKG_W-1:0] pos_to_onehot(input logic [PKG_IW-1:0] pos);
        logic [PKG_W-1:0] msb_only;
        msb_only = {1'b1, {(PKG_W-1){1'b0}}};
        return msb_only >> pos;
    endfunction

endpackage

// File: rtl/bitmask_scheduler_pencoder.sv
// Combinational MSB-first priority encoder: reports the index of the highest
// set bit (bit7 -> 0, bit0 -> 7) and flags an all-zero mask.
module pencoder_8to3
    import bitsim_pkg::*;
(
    input  logic [PKG_W-1:0]  mask,
    output logic [PKG_IW-1:0] pos,
    output logic              is_zero
);

    // Scan from bit 0 upward so the highest set bit is the last one to win.
    always_comb begin
        pos     = '0;
        is_zero = (mask == '0);
        for (int i = 0; i < PKG_W; i++) begin
            if (mask[i]) begin
                pos = PKG_IW'(PKG_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/bitmask_scheduler.sv
// Bitmask scheduler: accepts an operand bitmask and emits one beat per set bit,
// MSB first, with a single out_zero beat for an all-zero operand. The last beat
// of one operand can overlap acceptance of the next, giving zero-bubble streaming.
module bitmask_scheduler
    import bitsim_pkg::*;
#(
    parameter int W  = PKG_W,
    parameter int IW = PKG_IW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_bitmask,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_pos,
    output logic          out_last,
    output logic          out_zero
);

    state_t         state_q, state_d;
    logic [W-1:0]   residue_q, residue_d;

    logic [IW-1:0]  enc_pos;
    logic           enc_zero;
    logic           busy;
    logic           at_most_one;
    logic           in_fire;
    logic           out_fire;

    pencoder_8to3 u_pencoder (
        .mask    (residue_q),
        .pos     (enc_pos),
        .is_zero (enc_zero)
    );

    // Decode handshake and beat outputs purely from state and residue.
    always_comb begin
        busy        = (state_q == BUSY);
        at_most_one = ((residue_q & (residue_q - W'(1))) == '0);
        out_valid   = busy;
        out_pos     = busy ? enc_pos : '0;
        out_last    = busy && at_most_one;
        out_zero    = busy && enc_zero;
        // in_ready must stay low throughout reset even though state is already IDLE.
        in_ready    = !reset && (!busy || (out_valid && out_last && out_ready));
        in_fire     = in_valid && in_ready;
        out_fire    = out_valid && out_ready;
    end

    // Next state: a new operand always wins (covers back-to-back on the last beat);
    // otherwise retire the reported bit or fall back to IDLE after the last beat.
    always_comb begin
        state_d   = state_q;
        residue_d = residue_q;
        if (in_fire) begin
            state_d   = BUSY;
            residue_d = in_bitmask;
        end else if (out_fire && out_last) begin
            state_d   = IDLE;
            residue_d = '0;
        end else if (out_fire) begin
            residue_d = residue_q & ~pos_to_onehot(enc_pos);
        end
    end

    // State and residue are the only storage; reset discards any partial operand.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            residue_q <= '0;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
        end
    end

endmodule

// File: doc/bitmask_scheduler.md
BITMASK_SCHEDULER -- requirements
Module: bitmask_scheduler

Interface
REQ-001 SHALL have parameter W, default 8, operand bitmask width; 8 is the only supported value.
REQ-002 SHALL have parameter IW, default 3, position index width, equal to log2(W).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_bitmask.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-007 SHALL have port in_bitmask  input  W  operand bitmask; a 1 marks an essential bit.
REQ-008 SHALL have port out_valid  output  1  out_pos/out_last/out_zero are valid.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the current beat.
REQ-010 SHALL have port out_pos  output  IW  MSB-first index of the current set bit (bit7 gives 0, bit0 gives 7).
REQ-011 SHALL have port out_last  output  1  current beat is the final beat of the operand.
REQ-012 SHALL have port out_zero  output  1  operand was all-zero; this beat carries no position.

Function
REQ-013 SHALL implement states IDLE and BUSY.
REQ-014 SHALL transfer an input only when in_valid and in_ready are both high in the same cycle.
REQ-015 SHALL transfer an output beat only when out_valid and out_ready are both high in the same cycle.
REQ-016 SHALL drive in_ready = (state==IDLE) or (out_valid and out_last and out_ready).
REQ-017 On an input transfer, SHALL load in_bitmask into a W-bit residue register and enter BUSY the next cycle; first out_valid appears 1 cycle after acceptance.
REQ-018 In BUSY, SHALL drive out_valid=1 and out_pos = priority encode of residue (highest set bit first).
REQ-019 SHALL assert out_last when the residue has at most one set bit.
REQ-020 On an output transfer that is not last, SHALL clear the residue bit just reported; exactly one beat per set bit, one beat per cycle while out_ready stays high.
REQ-021 A zero operand SHALL produce exactly one beat with out_zero=1, out_pos=0, out_last=1.
REQ-022 On a last-beat transfer with no simultaneous input transfer, SHALL return to IDLE.
REQ-023 On a last-beat transfer with a simultaneous input transfer, SHALL load the new operand and stay in BUSY (zero-bubble back-to-back).
REQ-024 While out_valid=1 and out_ready=0, SHALL hold out_pos, out_last, out_zero and the residue stable.
REQ-025 In IDLE, SHALL drive out_valid=0, and out_pos/out_last/out_zero=0.
REQ-026 SHALL ignore in_bitmask whenever in_ready=0.

Reset
REQ-027 Asserting reset at any time, including mid-operand, SHALL immediately force state=IDLE, residue=0, out_valid=0, out_pos=0, out_last=0, out_zero=0; the partial operand is discarded.
REQ-028 While reset is high, SHALL hold in_ready=0; after release, in_ready=1 in the first cycle.

Structure
REQ-029 SHALL take the state enum (IDLE, BUSY) and the W/IW constants from the shared package bitsim_pkg.
REQ-030 SHALL instantiate one combinational sub-module, pencoder_8to3, that maps an 8-bit mask to a 3-bit MSB-first index plus an is_zero flag.
REQ-031 SHALL use registers only for state and residue; all outputs are decoded from them.

Verification
REQ-032 With in_bitmask=8'b1010_0001 and out_ready held 1, SHALL produce 3 beats on consecutive cycles: pos 0, 2, 7, with out_last only on pos 7.
REQ-033 With in_bitmask=8'h00, SHALL produce one beat with out_zero=1, out_last=1, then return to IDLE.
REQ-034 With two operands 8'h80 then 8'h03 offered back-to-back, SHALL produce beats 0(last), 6, 7(last) with no idle cycle between the operands.
REQ-035 With 8'hFF and out_ready toggled 1,0,1,0: SHALL produce 8 beats pos 0..7 in order, with values held stable during stalls.
REQ-036 With reset pulsed after 2 of 4 beats of 8'hF0, SHALL drop out_valid immediately; a new 8'h01 afterwards SHALL yield a single beat, pos 7, last.
